aes_inv_key_sched: RTL and testbench
====================================

# aes_inv_key_sched

Sequential AES-128 key scheduler for the decryption datapath. It accepts the cipher key and runs the schedule forward one round per cycle to reach the round-10 key. It then streams the round keys in reverse order (round 10 down to round 0) over a valid/ready handshake, recovering each earlier key with the inverse key recurrence so that no 11-entry key store is needed. It feeds the inverse-cipher round unit, which consumes keys in the order it applies AddRoundKey.

## Interface
- NK, 4, key length in 32-bit words; only 4 is supported.
- NR, 10, number of rounds; only 10 is supported.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- key  in  [0:127]  cipher key, byte 0 at bits [0:7]; captured on accepted start
- busy  out  1  high from the cycle after accepted start until done
- rk_valid  out  1  rk/rk_round hold a valid round key
- rk_ready  in  1  consumer accepts rk this cycle
- rk  out  [0:127]  round key, same word/byte ordering as key
- rk_round  out  4  round index of rk, 10..0
- done  out  1  one-cycle pulse after round 0 is accepted

## Operation
- States: IDLE, FWD, REV.
- **IDLE:**
  - start=1 captures key into the key register, sets r=0 and moves to FWD.
  - start while busy=1 is ignored.
- **FWD:** each cycle, key ← fwd_step(key, r+1) and r ← r+1.
  - fwd_step: t = SubWord(RotWord(w3)) ^ Rcon(r+1); n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - When r reaches 10, move to REV.
- **REV:**
  - rk_valid=1, rk = key register, rk_round = r.
  - On rk_valid & rk_ready with r>0: key ← inv_step(key, r) and r ← r−1.
  - inv_step: p3 = w3^w2, p2 = w2^w1, p1 = w1^w0, p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(r).
  - On handshake with r=0: go to IDLE and pulse done.
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the top byte; the other bytes are 0.
- Only one SubWord (4 S-boxes) exists. Its input is muxed: RotWord(w3) in FWD, RotWord(w2^w3) in REV.
- key input changes after capture have no effect.
- Round 0 emitted always equals the captured key. Verification uses this as a self-check.

## Timing
- Reset values: busy=0, rk_valid=0, rk=0, rk_round=0, done=0; state=IDLE, r=0.
- An asserted rst_n low aborts any operation immediately. After release the block is in IDLE with no pending key.
- Start accepted at edge E0. busy=1 after E0, through 10 FWD cycles.
- After edge E10, rk_valid=1 with rk_round=10.
- With rk_ready held high, one key per cycle: rounds 10..0 across 11 consecutive cycles.
- After the round-0 handshake edge: done=1 and busy=0 for one cycle, rk_valid=0.
- Start accepted at the earliest in the cycle after done, i.e. the first cycle with busy=0.
- rk_valid=1 with rk_ready=0: rk and rk_round are held stable, and no state advances.
- rk_ready is ignored when rk_valid=0.
- Minimum start-to-done latency is 22 cycles.

## Structure
- Shared package aes_pkg holds:
  - the S-box function
  - sub_word, rot_word
  - the rcon function (round index → 32-bit word)
  - the state enum
  - constants NK=4 and NR=10
- Sub-module aes_key_step: combinational, inputs key[0:127], round[3:0], dir (0=forward, 1=inverse); output next key. It contains the single shared SubWord.
- Top contains the FSM, the round counter, the key register and handshake logic.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 9 = ac7766f319fadc2128d12941575c006e
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 0 = input key
  - done exactly 22 cycles after start.
- All-zero key:
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e
  - round 1 = 62636363626363636263636362636363
  - round 0 = all zeros.
- Backpressure: rk_ready random (~50%) → rk and rk_round stable while stalled; sequence 10..0 unchanged, with no skipped or repeated rounds.
- Start pulsed and key changed during FWD and REV → ignored. The output sequence matches the originally captured key.
- rst_n asserted mid-REV at round 5 → all outputs return to reset values. A fresh start then produces the full correct sequence.
- Back-to-back operations with different random keys vs. a software reference model → all 11 keys per operation match. The next start is accepted in the first cycle after done.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule helpers: S-box, word rotations, round constants
// and the scheduler state type.
package aes_pkg;

    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        REV
    } state_t;

    // Byte n of the table sits at bits [8n:8n+7], matching the [0:N] byte order of the key bus
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [0:7] sbox(input logic [0:7] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [0:31] sub_word(input logic [0:31] w);
        return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
    endfunction

    function automatic logic [0:31] rot_word(input logic [0:31] w);
        return {w[8:31], w[0:7]};
    endfunction

    function automatic logic [0:31] rcon(input logic [3:0] round);
        logic [0:7] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step in either direction, built around a single
// shared SubWord so forward and inverse recurrences cost one set of S-boxes.
import aes_pkg::*;

module aes_key_step (
    input  logic [0:127] key,
    input  logic [3:0]   round,
    input  logic         dir,
    output logic [0:127] next_key
);

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] sub_in, t;
    logic [0:31] n0, n1, n2, n3;

    assign w0 = key[0:31];
    assign w1 = key[32:63];
    assign w2 = key[64:95];
    assign w3 = key[96:127];

    // Inverse direction needs the previous w3, which is w2^w3 of the current key
    assign sub_in = dir ? rot_word(w2 ^ w3) : rot_word(w3);
    assign t      = sub_word(sub_in) ^ rcon(round);

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_comb begin
        next_key = {n0, n1, n2, n3};
        if (dir) begin
            next_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
        end
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: walks forward to the round-10 key, then
// streams round keys 10..0 by undoing the schedule one step per handshake.
import aes_pkg::*;

module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk,
    output logic [3:0]   rk_round,
    output logic         done
);

    state_t       state;
    logic [3:0]   r;
    logic [0:127] key_q;
    logic [0:127] step_key;
    logic [3:0]   step_round;
    logic         step_dir;

    assign step_dir   = (state == REV);
    assign step_round = step_dir ? r : r + 4'd1;

    aes_key_step u_step (
        .key      (key_q),
        .round    (step_round),
        .dir      (step_dir),
        .next_key (step_key)
    );

    assign rk       = key_q;
    assign rk_round = r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            r        <= 4'd0;
            key_q    <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        key_q <= key;
                        r     <= 4'd0;
                        busy  <= 1'b1;
                        state <= FWD;
                    end
                end
                FWD: begin
                    key_q <= step_key;
                    r     <= r + 4'd1;
                    if (r == 4'(NR - 1)) begin
                        rk_valid <= 1'b1;
                        state    <= REV;
                    end
                end
                REV: begin
                    if (rk_ready) begin
                        if (r != 4'd0) begin
                            key_q <= step_key;
                            r     <= r - 4'd1;
                        end else begin
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: compares every streamed round key with a
// full forward key expansion computed from a GF(2^8)-derived S-box.
module tb_aes_inv_key_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [0:127] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [0:127] rk;
    logic [3:0]   rk_round;
    logic         done;

    int assert_count;
    int fail_count;

    logic [7:0]   sbox_tab [0:255];
    logic [7:0]   rcon_tab [1:10];
    logic [127:0] exp_keys [0:10];
    logic [127:0] got      [0:10];

    aes_inv_key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_round (rk_round),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8)
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] rc;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            rcon_tab[i] = rc;
            rc = gmul(rc, 8'h02);
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                    ^ {rcon_tab[i / 4], 24'h000000};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_rk"}, 128'(rk), 128'h0);
        checkOutput({tag, "_rk_round"}, 128'(rk_round), 128'h0);
        checkOutput({tag, "_busy"}, 128'(busy), 128'h0);
        checkOutput({tag, "_rk_valid"}, 128'(rk_valid), 128'h0);
        checkOutput({tag, "_done"}, 128'(done), 128'h0);
    endtask

    // Called at a negedge with the block idle; returns at the negedge where done is seen
    task automatic applyStimulus(input logic [127:0] k, input bit rand_ready, input bit perturb, input int abort_round);
        int  cyc;
        int  exp_round;
        int  handshakes;
        bit  finished;
        bit  first_valid;
        bit  nr;
        model_expand(k);
        for (int i = 0; i <= 10; i++) got[i] = '0;
        key      = k;
        start    = 1'b1;
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start       = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
        key         = perturb ? {$urandom, $urandom, $urandom, $urandom} : k;
        cyc         = 0;
        exp_round   = 10;
        handshakes  = 0;
        finished    = 1'b0;
        first_valid = 1'b1;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            nr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 1) checkOutput("busy_after_start", 128'(busy), 128'h1);
            if (done) begin
                checkOutput("done_busy", 128'(busy), 128'h0);
                checkOutput("done_valid", 128'(rk_valid), 128'h0);
                checkOutput("done_handshakes", 128'(handshakes), 128'd11);
                if (!rand_ready) checkOutput("latency", 128'(cyc), 128'd22);
                start    = 1'b0;
                finished = 1'b1;
            end else if (rk_valid) begin
                if (first_valid) begin
                    checkOutput("first_valid_cycle", 128'(cyc), 128'd11);
                    first_valid = 1'b0;
                end
                if (exp_round < 0) begin
                    checkOutput("extra_round", 128'(rk_round), 128'hf);
                end else begin
                    checkOutput("rk_round", 128'(rk_round), 128'(exp_round));
                    checkOutput("rk", 128'(rk), exp_keys[exp_round]);
                    checkOutput("busy_rev", 128'(busy), 128'h1);
                    if (exp_round == abort_round) begin
                        start = 1'b0;
                        rst_n = 1'b0;
                        #1;
                        check_reset_outputs("abort");
                        @(negedge clk);
                        check_reset_outputs("abort_hold");
                        rst_n = 1'b1;
                        return;
                    end
                    if (nr) begin
                        got[exp_round] = rk;
                        exp_round--;
                        handshakes++;
                    end
                end
            end else begin
                checkOutput("busy_fwd", 128'(busy), 128'h1);
            end
            rk_ready = nr;
            if (!finished && perturb) begin
                start = 1'($urandom_range(0, 1));
                key   = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        if (!finished) checkOutput("timeout", 128'h0, 128'h1);
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        start        = 1'b0;
        key          = '0;
        rk_ready     = 1'b0;
        rst_n        = 1'b0;
        build_tables();

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] FIPS-197 key, ready held high");
        applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, -1);
        checkOutput("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("fips_r9", got[9], 128'hac7766f319fadc2128d12941575c006e);
        checkOutput("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("fips_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        $display("[TB] all-zero key");
        applyStimulus(128'h0, 1'b0, 1'b0, -1);
        checkOutput("zero_r10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        checkOutput("zero_r1", got[1], 128'h62636363626363636263636362636363);
        checkOutput("zero_r0", got[0], 128'h0);

        $display("[TB] random key with backpressure");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1);

        $display("[TB] start and key disturbed while busy");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, -1);

        $display("[TB] reset during round 5, then fresh start");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 5);
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, -1);

        $display("[TB] back-to-back random keys");
        for (int n = 0; n < 4; n++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'(n % 2), 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
